// File: rtl/fas_peak_detect.sv
// Serial spectral peak detector: one complex FFT bin per cycle, reports the strongest bin per frame.
// Optional FAS_SECOND_PEAK_EN adds tracking of the second-strongest bin (freq2/peak_mag2).
module fas_peak_detect #(
  parameter int NPT     = 16,
  parameter int DW      = 16,
  parameter int SKIP_DC = 0,
  parameter int IDXW    = $clog2(NPT)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bin_valid,
  input  logic                   bin_sof,
  input  logic signed [DW-1:0]   bin_re,
  input  logic signed [DW-1:0]   bin_im,
  output logic                   done,
  output logic [IDXW-1:0]        freq,
  output logic [2*DW-1:0]        peak_mag,
  output logic                   busy,
  output logic                   err
`ifdef FAS_SECOND_PEAK_EN
  ,
  output logic [IDXW-1:0]        freq2,
  output logic [2*DW-1:0]        peak_mag2
`endif
);

  localparam int MW = 2 * DW;
  localparam int SW = 2 * DW - 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPT - 1);

  typedef enum logic {IDLE, ACC} state_t;

  // |x|^2 is at most 2^(2DW-2), so it always fits in 2DW-1 unsigned bits
  function automatic logic [SW-1:0] square_mag(input logic signed [DW-1:0] x);
    logic [DW-1:0] a;
    a = x[DW-1] ? $unsigned(-x) : $unsigned(x);
    return SW'(a) * SW'(a);
  endfunction

  function automatic logic [MW-1:0] sum_mag(input logic [SW-1:0] a, input logic [SW-1:0] b);
    return MW'(a) + MW'(b);
  endfunction

  state_t          state, state_nxt;
  logic [IDXW-1:0] cnt, cnt_nxt;
  logic            fid, fid_nxt;
  logic            acc_in, first_in, last_in, abort;
  logic [IDXW-1:0] idx_in;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fid_nxt   = fid;
    acc_in    = 1'b0;
    first_in  = 1'b0;
    last_in   = 1'b0;
    abort     = 1'b0;
    idx_in    = '0;
    case (state)
      IDLE: begin
        if (bin_valid && bin_sof) begin
          acc_in    = 1'b1;
          first_in  = 1'b1;
          cnt_nxt   = IDXW'(1);
          fid_nxt   = ~fid;
          state_nxt = ACC;
        end
      end
      ACC: begin
        if (bin_valid) begin
          acc_in = 1'b1;
          if (bin_sof) begin
            // early sof: drop the partial frame and restart at index 0
            abort    = 1'b1;
            first_in = 1'b1;
            cnt_nxt  = IDXW'(1);
            fid_nxt  = ~fid;
          end else begin
            idx_in  = cnt;
            cnt_nxt = cnt + IDXW'(1);
            if (cnt == LAST_IDX) begin
              last_in   = 1'b1;
              state_nxt = IDLE;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      fid   <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fid   <= fid_nxt;
      err   <= abort;
    end
  end

  logic                 vld_p0, vld_p1, vld_p2;
  logic signed [DW-1:0] re_p0, im_p0;
  logic [IDXW-1:0]      idx_p0, idx_p1, idx_p2;
  logic                 first_p0, first_p1, first_p2;
  logic                 last_p0, last_p1, last_p2;
  logic                 fid_p0, fid_p1;
  logic                 kill_p1, kill_p2;
  logic [SW-1:0]        sqre_p1, sqim_p1;
  logic [MW-1:0]        sum_p2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0 <= 1'b0;
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p0 <= acc_in;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
    end
  end

  // ---- p0: accepted bin with its frame tags
  always_ff @(posedge clk) begin
    if (acc_in) begin
      re_p0    <= bin_re;
      im_p0    <= bin_im;
      idx_p0   <= idx_in;
      first_p0 <= first_in;
      last_p0  <= last_in;
      fid_p0   <= fid_nxt;
    end
  end

  // ---- p1: squared components; in-flight entries of an aborted frame get killed
  always_ff @(posedge clk) begin
    if (vld_p0) begin
      sqre_p1  <= square_mag(re_p0);
      sqim_p1  <= square_mag(im_p0);
      idx_p1   <= idx_p0;
      first_p1 <= first_p0;
      last_p1  <= last_p0;
      fid_p1   <= fid_p0;
      kill_p1  <= abort && (fid_p0 == fid);
    end
  end

  // ---- p2: squared magnitude
  always_ff @(posedge clk) begin
    if (vld_p1) begin
      sum_p2   <= sum_mag(sqre_p1, sqim_p1);
      idx_p2   <= idx_p1;
      first_p2 <= first_p1;
      last_p2  <= last_p1;
      kill_p2  <= kill_p1 || (abort && (fid_p1 == fid));
    end
  end

  // ---- S3: running-max comparator
  logic [MW-1:0]   max_mag, max_nxt, cand;
  logic [IDXW-1:0] max_idx, mi_nxt;
  logic            load, upd;
`ifdef FAS_SECOND_PEAK_EN
  logic [MW-1:0]   sec_mag, sec_nxt;
  logic [IDXW-1:0] sec_idx, si_nxt;
  logic            sec_ok, sok_nxt;
`endif

  // With SKIP_DC bin 0 only seeds the max; bin 1 is the first real candidate
  always_comb begin
    upd     = vld_p2 && !kill_p2;
    load    = first_p2 || (SKIP_DC != 0 && idx_p2 == IDXW'(1));
    cand    = (SKIP_DC != 0 && idx_p2 == '0) ? '0 : sum_p2;
    max_nxt = max_mag;
    mi_nxt  = max_idx;
    if (load || cand > max_mag) begin
      max_nxt = cand;
      mi_nxt  = idx_p2;
    end
`ifdef FAS_SECOND_PEAK_EN
    sec_nxt = sec_mag;
    si_nxt  = sec_idx;
    sok_nxt = sec_ok;
    if (load) begin
      sok_nxt = 1'b0;
    end else if (cand > max_mag) begin
      sec_nxt = max_mag;
      si_nxt  = max_idx;
      sok_nxt = 1'b1;
    end else if (!sec_ok || cand > sec_mag) begin
      sec_nxt = cand;
      si_nxt  = idx_p2;
      sok_nxt = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (upd) begin
      max_mag <= max_nxt;
      max_idx <= mi_nxt;
`ifdef FAS_SECOND_PEAK_EN
      sec_mag <= sec_nxt;
      sec_idx <= si_nxt;
      sec_ok  <= sok_nxt;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done      <= 1'b0;
      freq      <= '0;
      peak_mag  <= '0;
`ifdef FAS_SECOND_PEAK_EN
      freq2     <= '0;
      peak_mag2 <= '0;
`endif
    end else begin
      done <= upd && last_p2;
      if (upd && last_p2) begin
        freq      <= mi_nxt;
        peak_mag  <= max_nxt;
`ifdef FAS_SECOND_PEAK_EN
        freq2     <= si_nxt;
        peak_mag2 <= sec_nxt;
`endif
      end
    end
  end

  assign busy = (state == ACC) || vld_p0 || vld_p1 || vld_p2;

endmodule
